mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_ctrl_timer.sv | 28 ++
 rtl/mem_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl CPU-to-RAM bridge.
// Chip-select layout: reqAddress[31:24] picks one of CHIP_COUNT chips.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RESP
  } state_t;

  localparam int CHIP_COUNT   = 8;
  localparam int CHIP_SEL_MSB = 31;
  localparam int CHIP_SEL_LSB = 24;
  localparam int WAIT_CNT_W   = 4;

  function automatic logic chip_in_range(input logic [31:0] addr);
    return addr[CHIP_SEL_MSB:CHIP_SEL_LSB] < 8'(CHIP_COUNT);
  endfunction

endpackage

// File: rtl/mem_ctrl_timer.sv
// Down-counter that times the ACCESS phase: load, count down while enabled,
// done when the count reaches zero.
module mem_ctrl_timer
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  done
);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Single-request CPU-to-RAM controller: IDLE -> SETUP -> ACCESS -> HOLD -> RESP.
// Optional macro MEM_CTRL_RANGE_CHECK_EN rejects chip selects above 7 with rspErr.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqRw,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic [31:0] ramAddress,
  output logic [31:0] ramDataIn,
  output logic        ramRw,
  input  logic [31:0] ramOut
);

  localparam logic [WAIT_CNT_W-1:0] ACCESS_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t state;
  logic   cap_rw;
  logic   addr_bad;
  logic   tmr_done;

`ifdef MEM_CTRL_RANGE_CHECK_EN
  assign addr_bad = !chip_in_range(reqAddress);
`else
  assign addr_bad = 1'b0;
`endif

  mem_ctrl_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == SETUP),
    .en       (state == ACCESS),
    .load_val (ACCESS_LOAD),
    .done     (tmr_done)
  );

  // ramAddress/ramDataIn double as the captured request registers, so they
  // only move on a handshake and are frozen for the whole write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      reqReady   <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      rspErr     <= 1'b0;
      ramAddress <= '0;
      ramDataIn  <= '0;
      ramRw      <= 1'b0;
      cap_rw     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          reqReady <= 1'b1;
          if (reqValid && reqReady) begin
            reqReady <= 1'b0;
            cap_rw   <= reqRw;
            if (addr_bad) begin
              rspErr   <= 1'b1;
              rspData  <= '0;
              rspValid <= 1'b1;
              state    <= RESP;
            end else begin
              rspErr     <= 1'b0;
              ramAddress <= reqAddress;
              ramDataIn  <= reqData;
              state      <= SETUP;
            end
          end
        end
        SETUP: begin
          ramRw <= cap_rw;
          state <= ACCESS;
        end
        ACCESS: begin
          if (tmr_done) begin
            ramRw <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          rspData  <= cap_rw ? '0 : ramOut;
          rspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            reqReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          ramRw <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
